// File: rtl/single_bit_resp_checker.sv
// Response checker for a single-bit DUT: compares resp_in against the (delayed, optionally inverted)
// stimulus and reports error counts and pass/fail. Optional macro: CHECKER_STOP_ON_FAIL_EN.
module single_bit_resp_checker #(
    parameter int unsigned LATENCY = 0,
    parameter int unsigned INVERT  = 1,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             stim_in,
    input  logic             resp_in,
    output logic             active,
    output logic             done,
    output logic             pass,
    output logic             overflow,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned SettleTotal = SETTLE + LATENCY;
    localparam int unsigned SW = (SettleTotal > 1) ? $clog2(SettleTotal + 1) : 1;
    localparam logic [SW-1:0] SettleLoad = SW'(SettleTotal);
    localparam logic [CNT_W-1:0] CntMax = '1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StCheck  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic             ovf_q, ovf_d;
    logic             delayed;
    logic             exp_bit;
    logic             mismatch;

    // Delay line runs in every state and is only cleared by reset.
    if (LATENCY == 0) begin : g_no_delay
        assign delayed = stim_in;
    end else begin : g_delay
        logic [LATENCY-1:0] dly_q;
        always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
                dly_q <= '0;
            end else begin
                dly_q <= (dly_q << 1) | LATENCY'(stim_in);
            end
        end
        assign delayed = dly_q[LATENCY-1];
    end

    assign exp_bit  = delayed ^ (INVERT != 0);
    assign mismatch = resp_in != exp_bit;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        err_d    = err_q;
        cyc_d    = cyc_q;
        first_d  = first_q;
        ovf_d    = ovf_q;
        if (start) begin
            // Restart from any state; start takes priority over stop.
            state_d  = StSettle;
            settle_d = SettleLoad;
            err_d    = '0;
            cyc_d    = '0;
            first_d  = CntMax;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                StSettle: begin
                    if (stop) begin
                        state_d = StDone;
                    end else if (settle_q == '0) begin
                        state_d = StCheck;
                    end else begin
                        settle_d = settle_q - SW'(1);
                    end
                end
                StCheck: begin
                    if (stop) begin
                        state_d = StDone;
                    end else begin
                        if (cyc_q != CntMax) begin
                            cyc_d = cyc_q + CNT_W'(1);
                        end
                        if (mismatch) begin
                            if (err_q != CntMax) begin
                                err_d = err_q + CNT_W'(1);
                            end
                            if (err_q == '0) begin
                                first_d = cyc_q;
                            end
`ifdef CHECKER_STOP_ON_FAIL_EN
                            state_d = StDone;
`endif
                        end
                        if (cyc_d == CntMax) begin
                            ovf_d   = 1'b1;
                            state_d = StDone;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            settle_q <= '0;
            err_q    <= '0;
            cyc_q    <= '0;
            first_q  <= CntMax;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
            first_q  <= first_d;
            ovf_q    <= ovf_d;
        end
    end

    assign active          = (state_q == StSettle) || (state_q == StCheck);
    assign done            = state_q == StDone;
    assign pass            = done && (err_q == '0) && !ovf_q;
    assign overflow        = ovf_q;
    assign err_cnt         = err_q;
    assign first_err_cycle = first_q;
    assign cycle_cnt       = cyc_q;

endmodule

// File: tb/tb_single_bit_resp_checker.sv
// Scoreboard bench: instance A uses the default parameters, instance B a delayed, non-inverting,
// 4-bit-counter configuration so overflow is reachable.
module tb_single_bit_resp_checker;

    typedef struct {
        int errs;
        int cyc;
        int first;
        bit ovf;
        bit pass;
    } exp_t;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic stim_in = 1'b0;
    logic resp_a = 1'b0;
    logic resp_b = 1'b0;

    logic        active_a, done_a, pass_a, ovf_a;
    logic [15:0] err_a, first_a, cyc_a;
    logic        active_b, done_b, pass_b, ovf_b;
    logic [3:0]  err_b, first_b, cyc_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    bit   st_arr[64];
    bit   ra_arr[64];
    bit   rb_arr[64];
    bit   done_a_prev = 1'b0;
    bit   done_b_prev = 1'b0;

    single_bit_resp_checker u_dut_a (
        .clock           (clock),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .stim_in         (stim_in),
        .resp_in         (resp_a),
        .active          (active_a),
        .done            (done_a),
        .pass            (pass_a),
        .overflow        (ovf_a),
        .err_cnt         (err_a),
        .first_err_cycle (first_a),
        .cycle_cnt       (cyc_a)
    );

    single_bit_resp_checker #(
        .LATENCY (2),
        .INVERT  (0),
        .SETTLE  (1),
        .CNT_W   (4)
    ) u_dut_b (
        .clock           (clock),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .stim_in         (stim_in),
        .resp_in         (resp_b),
        .active          (active_b),
        .done            (done_b),
        .pass            (pass_b),
        .overflow        (ovf_b),
        .err_cnt         (err_b),
        .first_err_cycle (first_b),
        .cycle_cnt       (cyc_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Offset 0 is the start edge; stop is sampled at offset d.
    function automatic exp_t model(input bit inst, input int d);
        int   t    = inst ? 3 : 2;
        int   lat  = inst ? 2 : 0;
        bit   inv  = inst ? 1'b0 : 1'b1;
        int   maxv = inst ? 15 : 65535;
        bit   ended = 1'b0;
        exp_t r;
        r.errs  = 0;
        r.cyc   = 0;
        r.first = maxv;
        r.ovf   = 1'b0;
        for (int j = t + 2; j < d && !ended; j++) begin
            bit resp = inst ? rb_arr[j] : ra_arr[j];
            bit mism = resp != (st_arr[j-lat] ^ inv);
            if (mism) begin
                if (r.errs == 0) r.first = r.cyc;
                if (r.errs < maxv) r.errs++;
            end
            r.cyc++;
            if (r.cyc == maxv) begin
                r.ovf = 1'b1;
                ended = 1'b1;
            end
`ifdef CHECKER_STOP_ON_FAIL_EN
            if (mism) ended = 1'b1;
`endif
        end
        r.pass = (r.errs == 0) && !r.ovf;
        return r;
    endfunction

    task automatic drive(input bit s, input bit p, input bit st, input bit ra, input bit rb);
        @(negedge clock);
        start   = s;
        stop    = p;
        stim_in = st;
        resp_a  = ra;
        resp_b  = rb;
    endtask

    task automatic run(input int d, input int pct, input bit combo, input bit pat,
                       input logic [63:0] fa, input logic [63:0] fb);
        int n = d + 4;
        for (int j = 0; j < n; j++) begin
            st_arr[j] = pat ? (j % 4 == 2) : 1'($urandom_range(0, 1));
        end
        for (int j = 0; j < n; j++) begin
            ra_arr[j] = ~st_arr[j] ^ (fa[j] || ($urandom_range(0, 99) < pct));
            rb_arr[j] = ((j >= 2) ? st_arr[j-2] : 1'b0) ^ (fb[j] || ($urandom_range(0, 99) < pct));
        end
        q_a.push_back(model(1'b0, d));
        q_b.push_back(model(1'b1, d));
        for (int j = 0; j < n; j++) begin
            drive(j == 0, (j == d) || (combo && j == 0), st_arr[j], ra_arr[j], rb_arr[j]);
            if (j == 0) begin
                @(posedge clock);
                #1;
                chk("a_active_after_start", int'(active_a), 1);
                chk("b_active_after_start", int'(active_b), 1);
                chk("a_done_after_start", int'(done_a), 0);
                chk("a_err_cleared", int'(err_a), 0);
                chk("a_cyc_cleared", int'(cyc_a), 0);
                chk("b_ovf_cleared", int'(ovf_b), 0);
            end
        end
    endtask

    task automatic chk_reset_vals();
        chk("a_rst_active", int'(active_a), 0);
        chk("a_rst_done", int'(done_a), 0);
        chk("a_rst_pass", int'(pass_a), 0);
        chk("a_rst_ovf", int'(ovf_a), 0);
        chk("a_rst_err", int'(err_a), 0);
        chk("a_rst_cyc", int'(cyc_a), 0);
        chk("a_rst_first", int'(first_a), 65535);
        chk("b_rst_active", int'(active_b), 0);
        chk("b_rst_done", int'(done_b), 0);
        chk("b_rst_err", int'(err_b), 0);
        chk("b_rst_first", int'(first_b), 15);
    endtask

    task automatic mon_check(input bit inst);
        exp_t e;
        if ((inst ? q_b.size() : q_a.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got done rising, expected no pending result",
                     inst ? "b_unexpected_done" : "a_unexpected_done");
        end else begin
            if (inst) e = q_b.pop_front();
            else e = q_a.pop_front();
            chk(inst ? "b_err_cnt" : "a_err_cnt", inst ? int'(err_b) : int'(err_a), e.errs);
            chk(inst ? "b_cycle_cnt" : "a_cycle_cnt", inst ? int'(cyc_b) : int'(cyc_a), e.cyc);
            chk(inst ? "b_first_err" : "a_first_err", inst ? int'(first_b) : int'(first_a),
                e.first);
            chk(inst ? "b_overflow" : "a_overflow", inst ? int'(ovf_b) : int'(ovf_a),
                int'(e.ovf));
            chk(inst ? "b_pass" : "a_pass", inst ? int'(pass_b) : int'(pass_a), int'(e.pass));
        end
    endtask

    always @(negedge clock) begin
        if (rst) begin
            done_a_prev <= 1'b0;
            done_b_prev <= 1'b0;
        end else begin
            if (done_a && !done_a_prev) mon_check(1'b0);
            if (done_b && !done_b_prev) mon_check(1'b1);
            done_a_prev <= done_a;
            done_b_prev <= done_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_reset_vals();
        @(negedge clock);
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 20 clean compares with the 0,0,1,0 pattern; B overflows before stop.
        run(24, 0, 1'b0, 1'b1, 64'h0, 64'h0);
        // Mismatches at compare cycles 5 and 9 on A.
        run(24, 0, 1'b0, 1'b1, (64'd1 << 9) | (64'd1 << 13), 64'h0);
        // Stop during settle: nothing compared.
        run(2, 0, 1'b0, 1'b0, 64'h0, 64'h0);

        // Restart mid-check with start and stop together: back to settle, not done.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (7) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run(12, 5, 1'b1, 1'b0, 64'h0, 64'h0);

        // Asynchronous reset in the middle of a check with three errors on A.
`ifdef CHECKER_STOP_ON_FAIL_EN
        q_a.push_back('{errs: 1, cyc: 1, first: 0, ovf: 1'b0, pass: 1'b0});
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int j = 1; j < 7; j++) begin
            drive(1'b0, 1'b0, 1'b0, (j >= 4) ? 1'b0 : 1'b1, 1'b0);
        end
        @(posedge clock);
        #1;
`ifdef CHECKER_STOP_ON_FAIL_EN
        chk("a_err_before_rst", int'(err_a), 1);
`else
        chk("a_err_before_rst", int'(err_a), 3);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals();
        @(negedge clock);
        rst = 1'b0;
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 25; i++) begin
            run(int'($urandom_range(1, 35)), (i % 3 == 0) ? 0 : 10, 1'b0, 1'b0, 64'h0, 64'h0);
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("a_pending_results", q_a.size(), 0);
        chk("b_pending_results", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
